dmem_port_arbiter: RTL and testbench

Shares the single data-side block-RAM port (port B, byte-write-enable, 32-bit word, byte-addressed 16-bit address) between the CPU load/store unit (requester 0) and the UART memory-access engine (requester 1). It provides per-cycle round-robin arbitration, an optional bounded lock for multi-beat transfers, and read-response routing that tracks the RAM's fixed read latency. It sits between the requesters and the RAM port B pins; the RAM itself is not modified.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/rd_tag_pipe.sv | 47 ++++
 rtl/dmem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-side memory port: widths, requester IDs,
// and the read-response tag carried alongside in-flight reads.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 16;
  localparam int BE_W   = 4;

  // Lock run counter width; saturates at its maximum value.
  localparam int CNT_W  = 8;

  // Requester identifiers, also used as bit positions in gnt/rvalid.
  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_UART = 1'b1;

  // One tag per accepted access: valid marks a read that expects data back.
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  // One-hot requester mask for a requester ID.
  function automatic logic [1:0] id_to_mask(input logic id);
    logic [1:0] mask;
    mask     = 2'b00;
    mask[id] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep shift register of {valid, id} tags. A tag pushed at an accept
// edge emerges at the output exactly RD_LAT cycles later, in step with the
// RAM's read data. Reset drops every tag, so in-flight reads are forgotten.
module rd_tag_pipe
  import mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_valid_i,
  input  logic push_id_i,
  output logic pop_valid_o,
  output logic pop_id_o
);

  rd_tag_t stage_q [RD_LAT];
  rd_tag_t stage_d [RD_LAT];

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
      // Stage 0 takes the new tag; later stages take the previous stage.
      always_comb begin
        stage_d[gi] = '0;
        if (gi == 0) begin
          stage_d[gi] = '{valid: push_valid_i, id: push_id_i};
        end else begin
          stage_d[gi] = stage_q[(gi == 0) ? 0 : gi - 1];
        end
      end

      // Stage register, cleared asynchronously.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_q[gi] <= '0;
        end else begin
          stage_q[gi] <= stage_d[gi];
        end
      end
    end
  endgenerate

  assign pop_valid_o = stage_q[RD_LAT-1].valid;
  assign pop_id_o    = stage_q[RD_LAT-1].id;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the data-side block-RAM port B. Per-cycle
// round-robin with an optional bounded lock, plus read-response routing that
// follows the RAM's fixed read latency through rd_tag_pipe.
module dmem_port_arbiter
  import mem_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        lock,
  input  logic [BE_W-1:0]   we0,
  input  logic [BE_W-1:0]   we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WORD_W-1:0] wdata0,
  input  logic [WORD_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [WORD_W-1:0] rdata,
  output logic [BE_W-1:0]   ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_din,
  input  logic [WORD_W-1:0] ram_dout
);

  localparam logic [CNT_W-1:0] MAX_LOCK_C = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

  // Last winner; resets to requester 1 so requester 0 takes the first tie.
  logic              last_q, last_d;
  // Lock state: a locking holder exists, who it is, and its run length.
  logic              hold_q, hold_d;
  logic              hold_id_q, hold_id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Last driven address/data, held on the RAM pins while idle.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] din_q, din_d;

  logic              hold_active;
  logic              win_valid;
  logic              win_id;
  logic [BE_W-1:0]   sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [WORD_W-1:0] sel_din;
  logic              pop_valid;
  logic              pop_id;

  // Pick the winner: a live, uncapped lock holder first, else round-robin.
  always_comb begin
    hold_active = hold_q && req[hold_id_q] && (cnt_q < MAX_LOCK_C);
    win_valid   = 1'b0;
    win_id      = REQ_CPU;
    if (rst_n) begin
      if (hold_active) begin
        win_valid = 1'b1;
        win_id    = hold_id_q;
      end else begin
        unique case (req)
          2'b01:   begin win_valid = 1'b1; win_id = REQ_CPU;  end
          2'b10:   begin win_valid = 1'b1; win_id = REQ_UART; end
          2'b11:   begin win_valid = 1'b1; win_id = ~last_q;  end
          default: begin win_valid = 1'b0; win_id = REQ_CPU;  end
        endcase
      end
    end
  end

  // Steer the winner's fields onto the RAM pins; idle keeps addr/din.
  always_comb begin
    sel_we   = (win_id == REQ_UART) ? we1    : we0;
    sel_addr = (win_id == REQ_UART) ? addr1  : addr0;
    sel_din  = (win_id == REQ_UART) ? wdata1 : wdata0;
    gnt      = win_valid ? id_to_mask(win_id) : 2'b00;
    ram_we   = win_valid ? sel_we   : '0;
    ram_addr = win_valid ? sel_addr : addr_q;
    ram_din  = win_valid ? sel_din  : din_q;
  end

  // Next state for last winner, lock run and held pin values.
  always_comb begin
    last_d    = last_q;
    hold_d    = 1'b0;
    hold_id_d = hold_id_q;
    cnt_d     = '0;
    addr_d    = addr_q;
    din_d     = din_q;
    if (win_valid) begin
      last_d = win_id;
      addr_d = sel_addr;
      din_d  = sel_din;
      if (lock[win_id]) begin
        hold_d    = 1'b1;
        hold_id_d = win_id;
        // Continue the run only if this grant came from the lock itself;
        // a capped holder winning again by plain arbitration starts afresh.
        if (hold_active) begin
          cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        end else begin
          cnt_d = CNT_W'(1);
        end
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= REQ_UART;
      hold_q    <= 1'b0;
      hold_id_q <= REQ_CPU;
      cnt_q     <= '0;
      addr_q    <= '0;
      din_q     <= '0;
    end else begin
      last_q    <= last_d;
      hold_q    <= hold_d;
      hold_id_q <= hold_id_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
    end
  end

  // Accepted reads push a valid tag; writes and idle cycles push a bubble.
  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (win_valid && (sel_we == '0)),
    .push_id_i    (win_id),
    .pop_valid_o  (pop_valid),
    .pop_id_o     (pop_id)
  );

  assign rvalid = pop_valid ? id_to_mask(pop_id) : 2'b00;
  assign rdata  = ram_dout;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a behavioural port-B RAM plus a reference
// model of grants, held pins and read responses (queue of due responses).
module tb_dmem_port_arbiter;

  localparam int TB_RD_LAT   = 2;
  localparam int TB_MAX_LOCK = 4;

  logic        clk, rst_n;
  logic [1:0]  req, lock;
  logic [3:0]  we0, we1;
  logic [15:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic [3:0]  ram_we;
  logic [15:0] ram_addr;
  logic [31:0] ram_din, ram_dout;

  dmem_port_arbiter #(.RD_LAT(TB_RD_LAT), .MAX_LOCK(TB_MAX_LOCK)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(input int i);
    return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
  endfunction

  // Port-B RAM: byte-enable write, read-first, TB_RD_LAT cycles to dout.
  logic [31:0] ram_mem  [0:255];
  logic [31:0] ram_pipe [0:TB_RD_LAT-1];
  logic        ram_inited = 1'b0;
  always @(posedge clk) begin
    if (!ram_inited) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= pattern(i);
      ram_inited <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram_mem[ram_addr[9:2]][8*b +: 8] <= ram_din[8*b +: 8];
      ram_pipe[0] <= ram_mem[ram_addr[9:2]];
      for (int s = 1; s < TB_RD_LAT; s++) ram_pipe[s] <= ram_pipe[s-1];
    end
  end
  assign ram_dout = ram_pipe[TB_RD_LAT-1];

  // Reference model state.
  typedef struct { int due; int id; logic [31:0] data; } rsp_t;
  rsp_t        rsp_q[$];
  logic [31:0] e_mem [0:255];
  int          m_last, m_owner, m_run, cyc;
  logic [15:0] e_addr_h;
  logic [31:0] e_din_h;

  logic [1:0]  e_gnt, e_rv, obs_gnt, obs_rv;
  logic [3:0]  e_we, obs_we;
  logic [15:0] e_addr, obs_addr;
  logic [31:0] e_din, e_rd, obs_din, obs_rdata, obs_rdm;
  logic [87:0] e_pk, obs_pk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic set_idle();
    req = 2'b00; lock = 2'b00; we0 = 4'h0; we1 = 4'h0;
    addr0 = 16'h0; addr1 = 16'h0; wdata0 = 32'h0; wdata1 = 32'h0;
  endtask

  // Advance one cycle: predict, sample on the falling edge, pass the rising edge.
  task automatic tick();
    int win;
    logic held;
    logic [3:0] w;
    logic [15:0] a;
    logic [31:0] d;
    rsp_t r;
    e_rv = 2'b00; e_rd = 32'h0; e_gnt = 2'b00; e_we = 4'h0;
    if (!rst_n) begin
      rsp_q.delete(); m_last = 1; m_owner = -1; m_run = 0;
      e_addr_h = 16'h0; e_din_h = 32'h0;
    end else begin
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        r = rsp_q.pop_front(); e_rv[r.id] = 1'b1; e_rd = r.data;
      end
      held = (m_owner >= 0) && req[m_owner] && (m_run < TB_MAX_LOCK);
      if (held)              win = m_owner;
      else if (req == 2'b11) win = 1 - m_last;
      else if (req[0])       win = 0;
      else if (req[1])       win = 1;
      else                   win = -1;
      if (win >= 0) begin
        w = (win == 1) ? we1 : we0;
        a = (win == 1) ? addr1 : addr0;
        d = (win == 1) ? wdata1 : wdata0;
        e_gnt[win] = 1'b1; e_we = w; e_addr_h = a; e_din_h = d;
        if (w == 4'h0) begin
          r.due = cyc + TB_RD_LAT; r.id = win; r.data = e_mem[a[9:2]];
          rsp_q.push_back(r);
        end else begin
          for (int b = 0; b < 4; b++) if (w[b]) e_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
        end
        if (lock[win]) begin m_run = held ? m_run + 1 : 1; m_owner = win; end
        else begin m_run = 0; m_owner = -1; end
        m_last = win;
      end else begin
        m_run = 0; m_owner = -1;
      end
    end
    e_addr = e_addr_h; e_din = e_din_h;
    e_pk = {e_gnt, e_rv, e_we, e_addr, e_din, e_rd};
    @(negedge clk);
    obs_gnt = gnt; obs_rv = rvalid; obs_we = ram_we; obs_addr = ram_addr;
    obs_din = ram_din; obs_rdata = rdata;
    obs_rdm = (e_rv != 2'b00) ? rdata : 32'h0;
    obs_pk = {obs_gnt, obs_rv, obs_we, obs_addr, obs_din, obs_rdm};
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    req = 2'b11; lock = 2'b11; we0 = 4'hF; we1 = 4'h3;
    addr0 = 16'h1234; addr1 = 16'h5678; wdata0 = 32'h11111111; wdata1 = 32'h22222222;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++;
      if (obs_pk !== e_pk) begin n_fail++; $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc-1, obs_pk, e_pk); end
      n_chk++;
      if ({obs_gnt, obs_rv, obs_we, obs_addr, obs_din} !== 58'h0) begin
        n_fail++; $display("FAIL reset_zero cyc=%0d got gnt=%b rv=%b we=%h addr=%h din=%h exp all 0", cyc-1, obs_gnt, obs_rv, obs_we, obs_addr, obs_din);
      end
    end
    set_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    set_idle(); req = 2'b10; we1 = 4'hF; addr1 = 16'h0010; wdata1 = 32'hDEADBEEF;
    tick();
    n_chk++;
    if (obs_pk !== e_pk) begin n_fail++; $display("FAIL single_prep cyc=%0d got=%h exp=%h", cyc-1, obs_pk, e_pk); end
    set_idle(); req = 2'b01; addr0 = 16'h0010;
    tick();
    n_chk++;
    if (obs_gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt got=%b exp=01", obs_gnt); end
    set_idle();
    for (int k = 1; k <= TB_RD_LAT + 1; k++) begin
      tick();
      n_chk++;
      if (obs_pk !== e_pk) begin n_fail++; $display("FAIL single_model cyc=%0d got=%h exp=%h", cyc-1, obs_pk, e_pk); end
      if (k == TB_RD_LAT) begin
        n_chk++;
        if (obs_rv !== 2'b01 || obs_rdata !== 32'hDEADBEEF) begin
          n_fail++; $display("FAIL single_resp got rv=%b data=%h exp rv=01 data=deadbeef", obs_rv, obs_rdata);
        end
      end
      if (k == TB_RD_LAT + 1) begin
        n_chk++;
        if (obs_rv !== 2'b00) begin n_fail++; $display("FAIL single_pulse got rv=%b exp 00", obs_rv); end
      end
    end
  endtask

  task automatic test_contention();
    logic [1:0] want;
    set_idle(); rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 2'b11; addr0 = 16'h0040; addr1 = 16'h0044;
    for (int k = 0; k < 4; k++) begin
      tick();
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_chk++;
      if (obs_gnt !== want) begin n_fail++; $display("FAIL contention_gnt k=%0d got=%b exp=%b", k, obs_gnt, want); end
      n_chk++;
      if (obs_pk !== e_pk) begin n_fail++; $display("FAIL contention_model cyc=%0d got=%h exp=%h", cyc-1, obs_pk, e_pk); end
    end
    set_idle();
    for (int k = 0; k <= TB_RD_LAT; k++) begin
      tick();
      n_chk++;
      if (obs_pk !== e_pk) begin n_fail++; $display("FAIL contention_drain cyc=%0d got=%h exp=%h", cyc-1, obs_pk, e_pk); end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] wd [2];
    logic [3:0]  be [2];
    logic [31:0] want [2];
    wd[0] = 32'h12345678; be[0] = 4'hF; want[0] = 32'h12345678;
    wd[1] = 32'h000000AA; be[1] = 4'h1; want[1] = 32'h123456AA;
    for (int t = 0; t < 2; t++) begin
      set_idle(); req = 2'b10; we1 = be[t]; addr1 = 16'h0100; wdata1 = wd[t];
      tick();
      n_chk++;
      if (obs_pk !== e_pk) begin n_fail++; $display("FAIL wr_write cyc=%0d got=%h exp=%h", cyc-1, obs_pk, e_pk); end
      set_idle(); req = 2'b01; addr0 = 16'h0100;
      tick();
      set_idle();
      for (int k = 1; k <= TB_RD_LAT; k++) begin
        tick();
        n_chk++;
        if (obs_pk !== e_pk) begin n_fail++; $display("FAIL wr_model cyc=%0d got=%h exp=%h", cyc-1, obs_pk, e_pk); end
      end
      n_chk++;
      if (obs_rv !== 2'b01 || obs_rdata !== want[t]) begin
        n_fail++; $display("FAIL wr_data t=%0d got rv=%b data=%h exp rv=01 data=%h", t, obs_rv, obs_rdata, want[t]);
      end
    end
  endtask

  task automatic test_lock_cap();
    logic [1:0] want;
    set_idle(); req = 2'b10; lock = 2'b10; addr1 = 16'h0080;
    tick();
    n_chk++;
    if (obs_gnt !== 2'b10) begin n_fail++; $display("FAIL lock_first got=%b exp=10", obs_gnt); end
    req = 2'b11; addr0 = 16'h0084;
    for (int k = 1; k <= TB_MAX_LOCK + 1; k++) begin
      tick();
      want = (k == TB_MAX_LOCK) ? 2'b01 : 2'b10;
      n_chk++;
      if (obs_gnt !== want) begin n_fail++; $display("FAIL lock_cap k=%0d got=%b exp=%b", k, obs_gnt, want); end
      n_chk++;
      if (obs_pk !== e_pk) begin n_fail++; $display("FAIL lock_model cyc=%0d got=%h exp=%h", cyc-1, obs_pk, e_pk); end
    end
    set_idle();
    for (int k = 0; k <= TB_RD_LAT; k++) begin
      tick();
      n_chk++;
      if (obs_pk !== e_pk) begin n_fail++; $display("FAIL lock_drain cyc=%0d got=%h exp=%h", cyc-1, obs_pk, e_pk); end
    end
  endtask

  task automatic test_back_to_back();
    int ids [3];
    logic [15:0] ad [3];
    ids[0] = 0; ids[1] = 1; ids[2] = 0;
    ad[0] = 16'h0000; ad[1] = 16'h0004; ad[2] = 16'h0008;
    for (int k = 0; k < TB_RD_LAT + 4; k++) begin
      set_idle();
      if (k < 3) begin
        if (ids[k] == 0) begin req = 2'b01; addr0 = ad[k]; end
        else             begin req = 2'b10; addr1 = ad[k]; end
      end
      tick();
      n_chk++;
      if (obs_pk !== e_pk) begin n_fail++; $display("FAIL b2b_model cyc=%0d got=%h exp=%h", cyc-1, obs_pk, e_pk); end
      if (k >= TB_RD_LAT && k < TB_RD_LAT + 3) begin
        n_chk++;
        if (obs_rv !== ((ids[k-TB_RD_LAT] == 1) ? 2'b10 : 2'b01) || obs_rdata !== pattern(int'(ad[k-TB_RD_LAT]) / 4)) begin
          n_fail++; $display("FAIL b2b_resp k=%0d got rv=%b data=%h exp id=%0d data=%h", k, obs_rv, obs_rdata, ids[k-TB_RD_LAT], pattern(int'(ad[k-TB_RD_LAT]) / 4));
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    set_idle(); req = 2'b01; addr0 = 16'h0020;
    tick();
    set_idle(); req = 2'b10; addr1 = 16'h0024;
    tick();
    req = 2'b11; lock = 2'b11; rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_chk++;
      if ({obs_gnt, obs_rv, obs_we, obs_addr, obs_din} !== 58'h0) begin
        n_fail++; $display("FAIL midreset_zero got gnt=%b rv=%b we=%h addr=%h din=%h exp all 0", obs_gnt, obs_rv, obs_we, obs_addr, obs_din);
      end
    end
    set_idle(); rst_n = 1'b1;
    for (int k = 0; k < TB_RD_LAT + 2; k++) begin
      tick();
      n_chk++;
      if (obs_rv !== 2'b00) begin n_fail++; $display("FAIL midreset_rvalid k=%0d got=%b exp=00", k, obs_rv); end
    end
  endtask

  task automatic new_fields(input int i);
    logic [15:0] a;
    logic [3:0]  w;
    a = 16'($urandom_range(0, 63)) << 2;
    w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    req[i]  = 1'b1;
    lock[i] = ($urandom_range(0, 99) < 40);
    if (i == 0) begin we0 = w; addr0 = a; wdata0 = $urandom; end
    else        begin we1 = w; addr1 = a; wdata1 = $urandom; end
  endtask

  task automatic test_random();
    set_idle();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req[i]) lock[i] = 1'($urandom_range(0, 1));
        if (!req[i] && $urandom_range(0, 99) < 55) new_fields(i);
      end
      tick();
      n_chk++;
      if (obs_pk !== e_pk) begin n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc-1, obs_pk, e_pk); end
      for (int i = 0; i < 2; i++) begin
        if (e_gnt[i]) begin
          if ($urandom_range(0, 1) == 1) new_fields(i);
          else begin req[i] = 1'b0; lock[i] = 1'b0; end
        end
      end
    end
    set_idle();
    for (int k = 0; k < TB_RD_LAT + 2; k++) begin
      tick();
      n_chk++;
      if (obs_pk !== e_pk) begin n_fail++; $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc-1, obs_pk, e_pk); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) e_mem[i] = pattern(i);
    cyc = 0; m_last = 1; m_owner = -1; m_run = 0;
    e_addr_h = 16'h0; e_din_h = 32'h0;
    set_idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_read();
    test_contention();
    test_write_read();
    test_lock_cap();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
